conv_job_scheduler: RTL

CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

---
 rtl/conv_job_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/conv_job_scheduler.sv
// rtl/conv_job_scheduler.sv - two-requester round-robin job scheduler for a convolution coprocessor
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   req_i[1:0]                 level job requests, bit n = requester n
//   sizeY0_i, sizeY1_i [4:0]   input-signal length per requester, sampled at grant
//   gnt_o[1:0]                 one-hot grant, held from GRANT through REPORT
//   cop_sizeY_o[4:0]           latched length driven to the coprocessor
//   cop_start_o                one-cycle coprocessor start pulse
//   cop_done_i, cop_writeZ_i   coprocessor done pulse and Z-memory write strobe
//   job_done_o[1:0]            one-cycle completion pulse to the granted requester
//   job_err_o                  error flag, meaningful only while job_done_o != 0
//   wr_count_o[5:0]            writeZ pulses seen in the current or last job
//   sched_busy_o               high whenever the scheduler is not idle

module conv_job_scheduler #(
    parameter int SIZEH   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [4:0] sizeY0_i,
    input  logic [4:0] sizeY1_i,
    output logic [1:0] gnt_o,
    output logic [4:0] cop_sizeY_o,
    output logic       cop_start_o,
    input  logic       cop_done_i,
    input  logic       cop_writeZ_i,
    output logic [1:0] job_done_o,
    output logic       job_err_o,
    output logic [5:0] wr_count_o,
    output logic       sched_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    // A correct job produces sizeY + SIZEH - 1 output samples (6-bit arithmetic).
    localparam logic [5:0] SIZEH_M1  = 6'(SIZEH - 1);
    localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

    state_t     state;
    logic [9:0] tmo_cnt;
    logic       last_served;   // requester that completed the previous job

    logic       pick;          // requester chosen if a grant happens this cycle
    logic [5:0] wr_next;       // write count including this cycle's strobe
    logic [9:0] tmo_next;
    logic [5:0] exp_count;

    always_comb begin
        pick = req_i[1];
        if (req_i == 2'b11) begin
            pick = ~last_served;
        end
        wr_next = wr_count_o;
        if (cop_writeZ_i && (wr_count_o != 6'd63)) begin
            wr_next = wr_count_o + 6'd1;
        end
        tmo_next  = tmo_cnt + 10'd1;
        exp_count = {1'b0, cop_sizeY_o} + SIZEH_M1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            last_served  <= 1'b1;   // so requester 0 wins the first contention
            gnt_o        <= '0;
            cop_sizeY_o  <= '0;
            cop_start_o  <= 1'b0;
            job_done_o   <= '0;
            job_err_o    <= 1'b0;
            wr_count_o   <= '0;
            sched_busy_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        gnt_o        <= pick ? 2'b10 : 2'b01;
                        cop_sizeY_o  <= pick ? sizeY1_i : sizeY0_i;
                        wr_count_o   <= '0;
                        tmo_cnt      <= '0;
                        sched_busy_o <= 1'b1;
                        state        <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (cop_sizeY_o == 5'd0) begin
                        // Empty job: report an error without touching the coprocessor.
                        job_done_o <= gnt_o;
                        job_err_o  <= 1'b1;
                        state      <= S_REPORT;
                    end else begin
                        cop_start_o <= 1'b1;
                        state       <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    cop_start_o <= 1'b0;
                    state       <= S_RUN;
                end

                S_RUN: begin
                    wr_count_o <= wr_next;
                    tmo_cnt    <= tmo_next;
                    // Done wins over a timeout landing in the same cycle.
                    if (cop_done_i) begin
                        job_done_o <= gnt_o;
                        job_err_o  <= (wr_next != exp_count);
                        state      <= S_REPORT;
                    end else if (tmo_next == TMO_LIMIT) begin
                        job_done_o <= gnt_o;
                        job_err_o  <= 1'b1;
                        state      <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    job_done_o   <= '0;
                    job_err_o    <= 1'b0;
                    last_served  <= gnt_o[1];
                    gnt_o        <= '0;
                    sched_busy_o <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
